// File: rtl/pipeline_stage_skid.sv
// rtl/pipeline_stage_skid.sv - elastic pipeline stage, 2-entry skid buffer, registered in_ready, sync flush
// Optional perf counters (stall_cnt, full_cnt) enabled by defining PIPE_STAGE_PERF_EN.
module pipeline_stage_skid #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] full_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             deliver;

  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;
  assign out_data = main_q;

  // in_ready and out_valid are registered alongside the state so no ready path is combinational.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      main_q    <= RESET_VAL;
      skid_q    <= RESET_VAL;
    end else if (flush) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (accept) begin
            state     <= BUSY;
            main_q    <= in_data;
            out_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (accept && !deliver) begin
            state    <= FULL;
            skid_q   <= in_data;
            in_ready <= 1'b0;
          end else if (deliver && !accept) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            if (accept) main_q <= in_data;
            in_ready <= 1'b1;
          end
        end
        FULL: begin
          if (deliver) begin
            state    <= BUSY;
            main_q   <= skid_q;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  // Counters ignore flush and stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      full_cnt  <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if ((state == FULL) && (full_cnt != '1))          full_cnt  <= full_cnt + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] unused_perf;
  assign unused_perf = '0;
`endif

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// tb/tb_pipeline_stage_skid.sv - directed vector bench for pipeline_stage_skid
module tb_pipeline_stage_skid;
  localparam int          W  = 32;
  localparam logic [W-1:0] RV = 32'hDEAD_BEEF;
  localparam int          CW = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] full_cnt;
`endif

  pipeline_stage_skid #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_PERF_EN
    ,
    .stall_cnt (stall_cnt),
    .full_cnt  (full_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         f;
    logic         iv;
    logic [W-1:0] d;
    logic         ordy;
    logic         eov;
    logic         eir;
    logic [W-1:0] edata;
  } vec_t;

  vec_t vecs[20];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic f, input logic iv, input logic [W-1:0] d, input logic o);
    flush = f; in_valid = iv; in_data = d; out_ready = o;
  endtask

  function automatic vec_t mk(input logic f, input logic iv, input logic [W-1:0] d, input logic o,
                              input logic ev, input logic er, input logic [W-1:0] ed);
    vec_t v;
    v.f = f; v.iv = iv; v.d = d; v.ordy = o; v.eov = ev; v.eir = er; v.edata = ed;
    return v;
  endfunction

  initial begin
    // expected outputs are those seen just after the clock edge that samples the inputs
    vecs[0]  = mk(L, L, 32'h0,  H, L, H, RV);      // first edge after reset: in_ready rises
    vecs[1]  = mk(L, H, 32'h1,  H, H, H, 32'h1);   // stream
    vecs[2]  = mk(L, H, 32'h2,  H, H, H, 32'h2);
    vecs[3]  = mk(L, H, 32'h3,  H, H, H, 32'h3);
    vecs[4]  = mk(L, L, 32'h0,  H, L, H, 32'h3);
    vecs[5]  = mk(L, H, 32'hA,  L, H, H, 32'hA);   // backpressure
    vecs[6]  = mk(L, H, 32'hB,  L, H, L, 32'hA);   // FULL
    vecs[7]  = mk(L, H, 32'hE,  L, H, L, 32'hA);   // FULL refuses 0xE
    vecs[8]  = mk(L, L, 32'h0,  H, H, H, 32'hB);
    vecs[9]  = mk(L, L, 32'h0,  H, L, H, 32'hB);
    vecs[10] = mk(L, H, 32'h10, L, H, H, 32'h10);  // flush in FULL
    vecs[11] = mk(L, H, 32'h11, L, H, L, 32'h10);
    vecs[12] = mk(H, H, 32'hC,  L, L, H, 32'h0);
    vecs[13] = mk(L, L, 32'h0,  H, L, H, 32'h0);
    vecs[14] = mk(L, H, 32'h20, H, H, H, 32'h20);  // flush in BUSY with accept
    vecs[15] = mk(H, H, 32'h21, H, L, H, 32'h0);
    vecs[16] = mk(L, L, 32'h0,  H, L, H, 32'h0);
    vecs[17] = mk(L, H, 32'h22, H, H, H, 32'h22);
    vecs[18] = mk(L, L, 32'h0,  L, H, H, 32'h22);  // stalled output holds
    vecs[19] = mk(L, L, 32'h0,  H, L, H, 32'h22);

    reset_n = 1'b0;
    drive(L, L, 32'h0, H);
    step();
    chk("reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset in_ready", {31'b0, in_ready}, 32'h0);
    chk("reset out_data", out_data, RV);

    // flush while reset is held: reset wins
    drive(H, L, 32'h0, H);
    step();
    chk("reset+flush in_ready", {31'b0, in_ready}, 32'h0);
    drive(L, L, 32'h0, H);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].f, vecs[i].iv, vecs[i].d, vecs[i].ordy);
      step();
      chk($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].eov});
      chk($sformatf("vec%0d in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].eir});
      if (vecs[i].eov) chk($sformatf("vec%0d out_data", i), out_data, vecs[i].edata);
    end

    // async reset mid-stream in BUSY
    drive(L, H, 32'h55, L);
    step();
    chk("busy out_valid", {31'b0, out_valid}, 32'h1);
    drive(L, L, 32'h0, L);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async out_valid", {31'b0, out_valid}, 32'h0);
    chk("async in_ready", {31'b0, in_ready}, 32'h0);
    chk("async out_data", out_data, RV);
    @(negedge clk);
    reset_n = 1'b1;
    drive(L, L, 32'h0, H);
    step();
    chk("post-reset out_valid", {31'b0, out_valid}, 32'h0);
    chk("post-reset in_ready", {31'b0, in_ready}, 32'h1);
    chk("post-reset out_data", out_data, RV);

`ifdef PIPE_STAGE_PERF_EN
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("perf reset stall", {28'b0, stall_cnt}, 32'h0);
    chk("perf reset full", {28'b0, full_cnt}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    drive(L, H, 32'h77, L);
    step();
    drive(L, L, 32'h0, L);
    repeat (5) step();
    chk("stall_cnt 5", {28'b0, stall_cnt}, 32'd5);
    repeat (15) step();
    chk("stall_cnt sat", {28'b0, stall_cnt}, 32'd15);
    drive(L, H, 32'h78, L);
    step();
    drive(L, L, 32'h0, L);
    repeat (3) step();
    chk("full_cnt 3", {28'b0, full_cnt}, 32'd3);
    chk("full in_ready", {31'b0, in_ready}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running required finished");
    $fatal(1);
  end
endmodule
